// File: rtl/operand_fwd_stage_pkg.sv
// Shared types and constants for the ID->EX operand forwarding stage.
package operand_fwd_stage_pkg;
  localparam int DATA_W_DEFAULT = 64;
  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {FWD_RF, FWD_EX, FWD_MEM, FWD_WB} fwd_sel_t;
endpackage

// File: rtl/operand_fwd_stage_if.sv
// Bus bundle between the pipeline and the operand forwarding stage.
interface operand_fwd_stage_if
  import operand_fwd_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 16
);
  logic [DATA_W-1:0] rd1_in, rd2_in;
  logic [4:0]        rs1, rs2;
  logic              id_valid, id_regwrite, id_memread;
  logic [4:0]        id_rd;
  logic [DATA_W-1:0] ex_alu_result;
  logic [4:0]        mem_rd, wb_rd;
  logic              mem_regwrite, wb_regwrite;
  logic [DATA_W-1:0] mem_result, wb_data;
  logic              flush;

  logic              ex_valid, ex_regwrite, ex_memread;
  logic [4:0]        ex_rd;
  logic [DATA_W-1:0] ex_opA, ex_opB;
  fwd_sel_t          ex_fwd_a, ex_fwd_b;
  logic              stall_out;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rd1_in, rd2_in, rs1, rs2, id_valid, id_regwrite, id_memread, id_rd,
           ex_alu_result, mem_rd, wb_rd, mem_regwrite, wb_regwrite,
           mem_result, wb_data, flush,
    input  ex_valid, ex_regwrite, ex_memread, ex_rd, ex_opA, ex_opB,
           ex_fwd_a, ex_fwd_b, stall_out, stall_cnt
  );

  modport slave (
    input  rd1_in, rd2_in, rs1, rs2, id_valid, id_regwrite, id_memread, id_rd,
           ex_alu_result, mem_rd, wb_rd, mem_regwrite, wb_regwrite,
           mem_result, wb_data, flush,
    output ex_valid, ex_regwrite, ex_memread, ex_rd, ex_opA, ex_opB,
           ex_fwd_a, ex_fwd_b, stall_out, stall_cnt
  );
endinterface

// File: rtl/operand_fwd_stage_fwd_mux.sv
// Per-operand priority forwarding select: EX, then MEM, then WB, else register file.
module operand_fwd_mux
  import operand_fwd_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [4:0]        rs,
  input  logic              ex_hit_en,
  input  logic [4:0]        ex_rd,
  input  logic              mem_hit_en,
  input  logic [4:0]        mem_rd,
  input  logic              wb_hit_en,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] ex_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wb_data,
  output fwd_sel_t          sel,
  output logic [DATA_W-1:0] data
);
  // XZR reads as zero from the register file, so it never takes a bypass.
  always_comb begin
    sel = FWD_RF;
    if (rs != XZR) begin
      if (ex_hit_en && (ex_rd == rs))        sel = FWD_EX;
      else if (mem_hit_en && (mem_rd == rs)) sel = FWD_MEM;
      else if (wb_hit_en && (wb_rd == rs))   sel = FWD_WB;
    end
  end

  always_comb begin
    unique case (sel)
      FWD_EX:  data = ex_data;
      FWD_MEM: data = mem_data;
      FWD_WB:  data = wb_data;
      default: data = rf_data;
    endcase
  end
endmodule

// File: rtl/operand_fwd_stage.sv
// ID->EX pipeline register with operand forwarding and load-use stall detection.
module operand_fwd_stage
  import operand_fwd_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                reset,
  operand_fwd_stage_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  fwd_sel_t          sel_a, sel_b;
  logic [DATA_W-1:0] fwd_a, fwd_b;
  logic              ex_fwd_en, hazard;

  // A load in EX has no data yet; it can only be bypassed from MEM next cycle.
  assign ex_fwd_en = bus.ex_valid & bus.ex_regwrite & ~bus.ex_memread;

  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_a (
    .rs(bus.rs1), .ex_hit_en(ex_fwd_en), .ex_rd(bus.ex_rd),
    .mem_hit_en(bus.mem_regwrite), .mem_rd(bus.mem_rd),
    .wb_hit_en(bus.wb_regwrite), .wb_rd(bus.wb_rd),
    .rf_data(bus.rd1_in), .ex_data(bus.ex_alu_result),
    .mem_data(bus.mem_result), .wb_data(bus.wb_data),
    .sel(sel_a), .data(fwd_a)
  );

  operand_fwd_mux #(.DATA_W(DATA_W)) u_fwd_b (
    .rs(bus.rs2), .ex_hit_en(ex_fwd_en), .ex_rd(bus.ex_rd),
    .mem_hit_en(bus.mem_regwrite), .mem_rd(bus.mem_rd),
    .wb_hit_en(bus.wb_regwrite), .wb_rd(bus.wb_rd),
    .rf_data(bus.rd2_in), .ex_data(bus.ex_alu_result),
    .mem_data(bus.mem_result), .wb_data(bus.wb_data),
    .sel(sel_b), .data(fwd_b)
  );

  assign hazard = bus.id_valid & bus.ex_valid & bus.ex_memread & (bus.ex_rd != XZR) &
                  ((bus.ex_rd == bus.rs1) | (bus.ex_rd == bus.rs2));
  assign bus.stall_out = hazard & ~bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_regwrite <= 1'b0;
      bus.ex_memread  <= 1'b0;
      bus.ex_rd       <= XZR;
      bus.ex_opA      <= '0;
      bus.ex_opB      <= '0;
      bus.ex_fwd_a    <= FWD_RF;
      bus.ex_fwd_b    <= FWD_RF;
      bus.stall_cnt   <= '0;
    end else begin
      if (bus.flush || bus.stall_out) begin
        bus.ex_valid    <= 1'b0;
        bus.ex_regwrite <= 1'b0;
        bus.ex_memread  <= 1'b0;
        bus.ex_rd       <= XZR;
        bus.ex_opA      <= '0;
        bus.ex_opB      <= '0;
        bus.ex_fwd_a    <= FWD_RF;
        bus.ex_fwd_b    <= FWD_RF;
      end else begin
        bus.ex_valid    <= bus.id_valid;
        bus.ex_regwrite <= bus.id_valid & bus.id_regwrite;
        bus.ex_memread  <= bus.id_valid & bus.id_memread;
        bus.ex_rd       <= bus.id_rd;
        bus.ex_opA      <= fwd_a;
        bus.ex_opB      <= fwd_b;
        bus.ex_fwd_a    <= sel_a;
        bus.ex_fwd_b    <= sel_b;
      end
      if (bus.stall_out && (bus.stall_cnt != {CNT_W{1'b1}}))
        bus.stall_cnt <= bus.stall_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_operand_fwd_stage.sv
// Scoreboard bench: driver pushes model expectations, monitor pops and compares.
module tb_operand_fwd_stage;
  import operand_fwd_stage_pkg::*;

  localparam int DW   = 64;
  localparam int CW   = 16;
  localparam int CW_S = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fwd_stage_if #(.DATA_W(DW), .CNT_W(CW))   bus ();
  operand_fwd_stage_if #(.DATA_W(DW), .CNT_W(CW_S)) bus_s ();

  operand_fwd_stage #(.DATA_W(DW), .CNT_W(CW))   dut   (.clk(clk), .reset(reset), .bus(bus.slave));
  operand_fwd_stage #(.DATA_W(DW), .CNT_W(CW_S)) dut_s (.clk(clk), .reset(reset), .bus(bus_s.slave));

  // Narrow-counter twin sees identical stimulus to exercise counter saturation.
  assign bus_s.rd1_in        = bus.rd1_in;
  assign bus_s.rd2_in        = bus.rd2_in;
  assign bus_s.rs1           = bus.rs1;
  assign bus_s.rs2           = bus.rs2;
  assign bus_s.id_valid      = bus.id_valid;
  assign bus_s.id_regwrite   = bus.id_regwrite;
  assign bus_s.id_memread    = bus.id_memread;
  assign bus_s.id_rd         = bus.id_rd;
  assign bus_s.ex_alu_result = bus.ex_alu_result;
  assign bus_s.mem_rd        = bus.mem_rd;
  assign bus_s.wb_rd         = bus.wb_rd;
  assign bus_s.mem_regwrite  = bus.mem_regwrite;
  assign bus_s.wb_regwrite   = bus.wb_regwrite;
  assign bus_s.mem_result    = bus.mem_result;
  assign bus_s.wb_data       = bus.wb_data;
  assign bus_s.flush         = bus.flush;

  typedef struct {
    logic reset, flush, id_valid, id_regwrite, id_memread, mem_regwrite, wb_regwrite;
    logic [4:0] rs1, rs2, id_rd, mem_rd, wb_rd;
    logic [63:0] rd1, rd2, alu, mem_result, wb_data;
  } stim_t;

  typedef struct {
    logic v, rw, mr;
    logic [4:0] rd;
    logic [63:0] a, b;
    fwd_sel_t sa, sb;
    logic chk_data;
    int unsigned cnt;
  } ex_exp_t;

  stim_t    s;
  ex_exp_t  ex_q[$];
  logic     stall_q[$];
  int       checks = 0;
  int       failures = 0;

  // Reference state: what the EX stage should be holding right now.
  logic        m_v = 1'b0, m_rw = 1'b0, m_mr = 1'b0;
  logic [4:0]  m_rd = 5'd31;
  int unsigned m_cnt = 0;
  logic        last_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic void fwd_model(input logic [4:0] rs, input logic [63:0] rf,
                                    output logic [63:0] d, output fwd_sel_t sel);
    d = rf; sel = FWD_RF;
    if (rs == 5'd31) return;
    if (m_v && m_rw && !m_mr && m_rd == rs) begin d = s.alu; sel = FWD_EX; end
    else if (s.mem_regwrite && s.mem_rd == rs) begin d = s.mem_result; sel = FWD_MEM; end
    else if (s.wb_regwrite && s.wb_rd == rs) begin d = s.wb_data; sel = FWD_WB; end
  endfunction

  task automatic apply();
    reset             = s.reset;
    bus.flush         = s.flush;
    bus.id_valid      = s.id_valid;
    bus.id_regwrite   = s.id_regwrite;
    bus.id_memread    = s.id_memread;
    bus.id_rd         = s.id_rd;
    bus.rs1           = s.rs1;
    bus.rs2           = s.rs2;
    bus.rd1_in        = s.rd1;
    bus.rd2_in        = s.rd2;
    bus.ex_alu_result = s.alu;
    bus.mem_rd        = s.mem_rd;
    bus.mem_regwrite  = s.mem_regwrite;
    bus.mem_result    = s.mem_result;
    bus.wb_rd         = s.wb_rd;
    bus.wb_regwrite   = s.wb_regwrite;
    bus.wb_data       = s.wb_data;
  endtask

  task automatic nop_stim();
    s = '{reset: 1'b0, flush: 1'b0, id_valid: 1'b0, id_regwrite: 1'b0, id_memread: 1'b0,
          mem_regwrite: 1'b0, wb_regwrite: 1'b0, rs1: 5'd0, rs2: 5'd0, id_rd: 5'd0,
          mem_rd: 5'd0, wb_rd: 5'd0, rd1: 64'd0, rd2: 64'd0, alu: 64'd0,
          mem_result: 64'd0, wb_data: 64'd0};
  endtask

  // One cycle: drive s at the falling edge and queue what the model predicts.
  task automatic step();
    logic hz, st;
    ex_exp_t e;
    logic [63:0] da, db;
    fwd_sel_t sa, sb;
    @(negedge clk);
    apply();
    hz = s.id_valid && m_v && m_mr && (m_rd != 5'd31) && (m_rd == s.rs1 || m_rd == s.rs2);
    st = hz && !s.flush;
    stall_q.push_back(st);
    fwd_model(s.rs1, s.rd1, da, sa);
    fwd_model(s.rs2, s.rd2, db, sb);
    e = '{v: 1'b0, rw: 1'b0, mr: 1'b0, rd: 5'd31, a: 64'd0, b: 64'd0,
          sa: FWD_RF, sb: FWD_RF, chk_data: 1'b1, cnt: 0};
    if (s.reset) m_cnt = 0;
    else begin
      if (st) m_cnt = m_cnt + 1;
      if (!(s.flush || st)) begin
        e.v = s.id_valid; e.rw = s.id_valid && s.id_regwrite; e.mr = s.id_valid && s.id_memread;
        e.rd = s.id_rd; e.a = da; e.b = db; e.sa = sa; e.sb = sb; e.chk_data = s.id_valid;
      end
    end
    e.cnt = m_cnt;
    ex_q.push_back(e);
    m_v = e.v; m_rw = e.rw; m_mr = e.mr; m_rd = e.rd;
    last_stall = st;
  endtask

  task automatic cmp_ex(input string tag, input logic v, input logic rw, input logic mr,
                        input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b,
                        input fwd_sel_t fa, input fwd_sel_t fb, input ex_exp_t e);
    chk({tag, "ex_valid"}, v, e.v);
    chk({tag, "ex_regwrite"}, rw, e.rw);
    chk({tag, "ex_memread"}, mr, e.mr);
    if (e.chk_data) begin
      chk({tag, "ex_rd"}, rd, e.rd);
      chk({tag, "ex_opA"}, a, e.a);
      chk({tag, "ex_opB"}, b, e.b);
      chk({tag, "ex_fwd_a"}, fa, e.sa);
      chk({tag, "ex_fwd_b"}, fb, e.sb);
    end
  endtask

  initial begin : monitor
    logic st;
    ex_exp_t e;
    forever begin
      @(negedge clk); #2;
      if (stall_q.size() > 0) begin
        st = stall_q.pop_front();
        chk("stall_out", bus.stall_out, st);
        chk("s_stall_out", bus_s.stall_out, st);
      end
      @(posedge clk); #1;
      if (ex_q.size() > 0) begin
        e = ex_q.pop_front();
        cmp_ex("", bus.ex_valid, bus.ex_regwrite, bus.ex_memread, bus.ex_rd,
               bus.ex_opA, bus.ex_opB, bus.ex_fwd_a, bus.ex_fwd_b, e);
        cmp_ex("s_", bus_s.ex_valid, bus_s.ex_regwrite, bus_s.ex_memread, bus_s.ex_rd,
               bus_s.ex_opA, bus_s.ex_opB, bus_s.ex_fwd_a, bus_s.ex_fwd_b, e);
        chk("stall_cnt", bus.stall_cnt, (e.cnt > 65535) ? 64'd65535 : 64'(e.cnt));
        chk("s_stall_cnt", bus_s.stall_cnt, (e.cnt > 15) ? 64'd15 : 64'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  function automatic logic [4:0] rreg();
    int k = int'($urandom_range(0, 4));
    return (k == 4) ? 5'd31 : 5'(k);
  endfunction

  task automatic do_reset();
    nop_stim(); s.reset = 1'b1; step(); step();
    nop_stim(); step();
  endtask

  task automatic post_edge();
    @(posedge clk); #1;
  endtask

  initial begin : driver
    nop_stim(); s.reset = 1'b1; apply();
    do_reset();

    // ADD X1 in EX, dependent read of X1.
    nop_stim(); s.id_valid = 1; s.id_rd = 5'd1; s.id_regwrite = 1; step();
    nop_stim(); s.id_valid = 1; s.rs1 = 5'd1; s.rd1 = 64'h5; s.alu = 64'h10; s.id_rd = 5'd4; step();
    #2 chk("add_fwd_stall", bus.stall_out, 1'b0);
    post_edge(); chk("add_fwd_opA", bus.ex_opA, 64'h10);

    // LDUR X2 then a reader of X2: one bubble, then MEM bypass.
    do_reset();
    nop_stim(); s.id_valid = 1; s.id_rd = 5'd2; s.id_regwrite = 1; s.id_memread = 1; step();
    nop_stim(); s.id_valid = 1; s.rs2 = 5'd2; s.rd2 = 64'h7; s.id_rd = 5'd4; s.id_regwrite = 1; step();
    #2 chk("load_use_stall", bus.stall_out, 1'b1);
    post_edge(); chk("load_use_bubble_v", bus.ex_valid, 1'b0); chk("load_use_bubble_rd", bus.ex_rd, 5'd31);
    s.mem_rd = 5'd2; s.mem_regwrite = 1; s.mem_result = 64'hABCD; step();
    #2 chk("load_use_release", bus.stall_out, 1'b0);
    post_edge(); chk("load_use_opB", bus.ex_opB, 64'hABCD); chk("load_use_cnt", bus.stall_cnt, 16'd1);

    // EX > MEM > WB priority for X3.
    nop_stim(); s.id_valid = 1; s.id_rd = 5'd3; s.id_regwrite = 1; step();
    nop_stim(); s.id_valid = 1; s.rs1 = 5'd3; s.rd1 = 64'h9; s.id_rd = 5'd5;
    s.alu = 64'h1; s.mem_rd = 5'd3; s.mem_regwrite = 1; s.mem_result = 64'h2;
    s.wb_rd = 5'd3; s.wb_regwrite = 1; s.wb_data = 64'h3; step();
    post_edge(); chk("prio_ex", bus.ex_opA, 64'h1);
    step(); post_edge(); chk("prio_mem", bus.ex_opA, 64'h2);
    s.mem_regwrite = 0; step(); post_edge(); chk("prio_wb", bus.ex_opA, 64'h3);

    // X31 never forwards, and a load to X31 never stalls.
    nop_stim(); s.id_valid = 1; s.id_rd = 5'd31; s.id_regwrite = 1; s.id_memread = 1; step();
    nop_stim(); s.id_valid = 1; s.rs1 = 5'd31; s.rs2 = 5'd31; s.alu = 64'hFFFF;
    s.mem_rd = 5'd31; s.mem_regwrite = 1; s.mem_result = 64'hFFFF;
    s.wb_rd = 5'd31; s.wb_regwrite = 1; s.wb_data = 64'hFFFF; step();
    #2 chk("xzr_stall", bus.stall_out, 1'b0);
    post_edge(); chk("xzr_opA", bus.ex_opA, 64'h0); chk("xzr_opB", bus.ex_opB, 64'h0);

    // Flush beats a load-use stall; reset mid-stall clears everything.
    nop_stim(); s.id_valid = 1; s.id_rd = 5'd2; s.id_regwrite = 1; s.id_memread = 1; step();
    nop_stim(); s.id_valid = 1; s.rs1 = 5'd2; s.id_rd = 5'd6; s.id_regwrite = 1; s.flush = 1; step();
    #2 chk("flush_stall", bus.stall_out, 1'b0);
    post_edge(); chk("flush_bubble_v", bus.ex_valid, 1'b0); chk("flush_bubble_rw", bus.ex_regwrite, 1'b0);
    nop_stim(); s.id_valid = 1; s.id_rd = 5'd2; s.id_regwrite = 1; s.id_memread = 1; step();
    nop_stim(); s.id_valid = 1; s.rs1 = 5'd2; s.rd1 = 64'h55; s.id_rd = 5'd6; s.id_regwrite = 1; s.reset = 1; step();
    post_edge();
    chk("rst_mid_v", bus.ex_valid, 1'b0); chk("rst_mid_rd", bus.ex_rd, 5'd31);
    chk("rst_mid_opA", bus.ex_opA, 64'h0); chk("rst_mid_cnt", bus.stall_cnt, 16'd0);
    s.reset = 0; step();
    #2 chk("rst_after_stall", bus.stall_out, 1'b0);

    // Repeated self-dependent loads: 20 stalls, narrow counter pins at 15.
    do_reset();
    nop_stim(); s.id_valid = 1; s.rs1 = 5'd2; s.id_rd = 5'd2; s.id_regwrite = 1; s.id_memread = 1;
    for (int i = 0; i < 40; i++) step();
    post_edge(); chk("sat_cnt_wide", bus.stall_cnt, 16'd20); chk("sat_cnt_narrow", bus_s.stall_cnt, 4'd15);

    // Randomized traffic; ID is held while a stall is expected.
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        s.id_valid = ($urandom_range(0, 4) != 0); s.id_rd = rreg();
        s.id_regwrite = $urandom_range(0, 1) == 1; s.id_memread = ($urandom_range(0, 2) == 0);
        s.rs1 = rreg(); s.rs2 = rreg();
        s.rd1 = (s.rs1 == 5'd31) ? 64'd0 : {$urandom, $urandom};
        s.rd2 = (s.rs2 == 5'd31) ? 64'd0 : {$urandom, $urandom};
      end
      s.alu = {$urandom, $urandom}; s.mem_result = {$urandom, $urandom}; s.wb_data = {$urandom, $urandom};
      s.mem_rd = rreg(); s.wb_rd = rreg();
      s.mem_regwrite = $urandom_range(0, 1) == 1; s.wb_regwrite = $urandom_range(0, 1) == 1;
      s.flush = ($urandom_range(0, 9) == 0); s.reset = ($urandom_range(0, 63) == 0);
      step();
    end

    nop_stim(); step();
    repeat (3) post_edge();
    chk("queues_drained", 64'(ex_q.size() + stall_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/operand_fwd_stage.md
OPERAND_FWD_STAGE -- requirements
Module: operand_fwd_stage

Interface
REQ-001 Parameter DATA_W, default 64: operand and result width.
REQ-002 Parameter CNT_W, default 16: stall counter width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rd1_in  input  DATA_W  register file ReadData1 for rs1.
REQ-006 rd2_in  input  DATA_W  register file ReadData2 for rs2.
REQ-007 rs1, rs2  input  5  source register numbers of the ID instruction.
REQ-008 id_valid  input  1  ID instruction valid.
REQ-009 id_rd  input  5  ID destination register.
REQ-010 id_regwrite, id_memread  input  1  ID control: writes Rd; is a load.
REQ-011 ex_alu_result  input  DATA_W  combinational EX-stage ALU result for the instruction held in this block.
REQ-012 mem_rd  input  5  EX/MEM destination; mem_regwrite  input  1, valid-qualified; mem_result  input  DATA_W.
REQ-013 wb_rd  input  5  MEM/WB destination; wb_regwrite  input  1, valid-qualified; wb_data  input  DATA_W, same value driven to register file WriteData.
REQ-014 flush  input  1  squash the ID instruction (branch taken).
REQ-015 ex_valid, ex_regwrite, ex_memread  output  1  registered EX-stage control.
REQ-016 ex_rd  output  5  registered EX destination.
REQ-017 ex_opA, ex_opB  output  DATA_W  registered forwarded operands.
REQ-018 stall_out  output  1  combinational; holds PC and IF/ID when high.
REQ-019 stall_cnt  output  CNT_W  count of stall cycles.

Function
REQ-020 Operand select per source, first match wins: EX hit (ex_valid & ex_regwrite & ~ex_memread & ex_rd==rs) -> ex_alu_result; MEM hit (mem_regwrite & mem_rd==rs) -> mem_result; WB hit (wb_regwrite & wb_rd==rs) -> wb_data; otherwise rdN_in.
REQ-021 rs==31 never forwards; the operand is the register file value, which is zero.
REQ-022 Load-use hazard = id_valid & ex_valid & ex_memread & ex_rd!=31 & (ex_rd==rs1 | ex_rd==rs2).
REQ-023 stall_out = hazard & ~flush.
REQ-024 On posedge with no stall and no flush: ex_* <= ID control and forwarded operands; ex_valid <= id_valid.
REQ-025 On posedge with stall: insert a bubble (ex_valid<=0, ex_regwrite<=0, ex_memread<=0, ex_rd<=31); operands don't-care, driven 0.
REQ-026 The ID inputs are held externally during a stall, so exactly one bubble is inserted per load-use pair; the next cycle forwards from MEM.
REQ-027 On posedge with flush: insert a bubble as in REQ-025; flush has priority over stall.
REQ-028 When id_valid=0, the ID instruction is captured as a bubble (ex_regwrite<=0, ex_memread<=0).
REQ-029 stall_cnt increments by 1 on each cycle with stall_out=1 and saturates at all-ones.
REQ-030 Latency: forwarded operands appear on ex_opA/ex_opB one cycle after ID presentation.

Reset
REQ-031 While reset=1 at posedge: ex_valid=0, ex_regwrite=0, ex_memread=0, ex_rd=31, ex_opA=0, ex_opB=0, stall_cnt=0.
REQ-032 Reset overrides flush and stall; stall_out is 0 in the cycle after reset because ex_valid=0.
REQ-033 Reset asserted mid-stall discards the bubble and any pending capture.

Structure
REQ-034 The shared package holds the fwd_sel_t enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}, the constant XZR=5'd31, and the default DATA_W.
REQ-035 The one sub-module, operand_fwd_mux, takes rs, the hit qualifiers and four data inputs, and returns fwd_sel_t plus the data; it is instantiated once per operand.

Verification
REQ-036 ADD X1 in EX (result 0x10), ID reads X1 with rd1_in=0x5 -> ex_opA=0x10 next cycle, stall_out=0.
REQ-037 LDUR X2 in EX, ID reads rs2=2 -> stall_out=1 for exactly 1 cycle, a bubble, then ex_opB=mem_result=0xABCD; stall_cnt=1.
REQ-038 EX, MEM and WB all write X3 (0x1, 0x2, 0x3), ID reads rs1=3 -> ex_opA=0x1; with EX not writing -> 0x2; with only WB writing -> 0x3.
REQ-039 All stages write X31 with 0xFFFF, ID reads rs1=rs2=31 -> ex_opA=ex_opB=0, no stall even with a load to X31 in EX.
REQ-040 Load-use hazard together with flush=1 -> stall_out=0 and a bubble; reset during a stall -> all outputs take their REQ-031 values next cycle.
REQ-041 Force stall_cnt to 0xFFFF, then stall -> stall_cnt stays 0xFFFF.
